// File: rtl/prog_pkg.sv
// Shared types and helpers for the programming-path word packer.
package prog_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } state_e;

    // Expand per-lane byte enables into a full-width bit mask.
    function automatic logic [WORD_W-1:0] be_to_mask(input logic [LANES-1:0] be);
        logic [WORD_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/prog_word_packer.sv
// Packs receiver bytes into little-endian 32-bit instruction-memory writes.
// Optional feature: define PROG_CHECKSUM_EN to enable the per-session write checksum.
module prog_word_packer
    import prog_pkg::*;
#(
    parameter int unsigned BYTE_ADDR_W = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     session_i,
    input  logic                     we_i,
    input  logic [7:0]               data_i,
    input  logic [BYTE_ADDR_W-1:0]   byte_addr_i,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [BYTE_ADDR_W-3:0]   mem_addr_o,
    output logic [WORD_W-1:0]        mem_wdata_o,
    output logic [LANES-1:0]         mem_be_o,
    output logic                     cpu_rst_no,
    output logic                     overflow_o,
    output logic [BYTE_ADDR_W-2:0]   words_o,
    output logic [WORD_W-1:0]        checksum_o
);

    localparam int unsigned WaW  = BYTE_ADDR_W - 2;
    localparam int unsigned CntW = BYTE_ADDR_W - 1;

    state_e                 state_q, state_d;
    logic                   we_q, session_q;
    logic [WORD_W-1:0]      pack_data_q, pack_data_d;
    logic [LANES-1:0]       pack_be_q, pack_be_d;
    logic [WaW-1:0]         pack_addr_q, pack_addr_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [7:0]             skid_data_q, skid_data_d;
    logic [BYTE_ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic                   overflow_q, overflow_d;
    logic [CntW-1:0]        words_q, words_d;

    logic           capture, grant, start, addr_diff;
    logic [1:0]     cap_lane;
    logic [WaW-1:0] cap_waddr;

    assign capture   = we_i && !we_q && (state_q == StCollect || state_q == StWrite);
    assign cap_lane  = byte_addr_i[1:0];
    assign cap_waddr = byte_addr_i[BYTE_ADDR_W-1:2];
    assign addr_diff = (|pack_be_q) && (cap_waddr != pack_addr_q);
    assign grant     = (state_q == StWrite) && mem_gnt_i;
    assign start     = (state_q == StIdle) && session_i;

    always_comb begin
        state_d      = state_q;
        pack_data_d  = pack_data_q;
        pack_be_d    = pack_be_q;
        pack_addr_d  = pack_addr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_addr_d  = skid_addr_q;
        overflow_d   = overflow_q;
        words_d      = words_q;

        unique case (state_q)
            StIdle: begin
                if (session_i) begin
                    state_d      = StCollect;
                    pack_data_d  = '0;
                    pack_be_d    = '0;
                    skid_valid_d = 1'b0;
                    overflow_d   = 1'b0;
                    words_d      = '0;
                end
            end
            StCollect: begin
                if (capture && addr_diff) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = data_i;
                    skid_addr_d  = byte_addr_i;
                    state_d      = StWrite;
                end else if (capture) begin
                    pack_data_d[{cap_lane, 3'b000} +: 8] = data_i;
                    pack_be_d[cap_lane]                  = 1'b1;
                    pack_addr_d                          = cap_waddr;
                    if (cap_lane == 2'd3 || !session_i) begin
                        state_d = StWrite;
                    end
                end else if ((|pack_be_q) && (pack_be_q[3] || !session_i)) begin
                    // Covers a full word or a session-end remainder left by the skid byte.
                    state_d = StWrite;
                end else if (!session_i && !session_q) begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                if (capture && !grant) begin
                    if (skid_valid_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = data_i;
                        skid_addr_d  = byte_addr_i;
                    end
                end
                if (grant) begin
                    pack_data_d = '0;
                    pack_be_d   = '0;
                    words_d     = (&words_q) ? words_q : words_q + CntW'(1);
                    if (skid_valid_q) begin
                        pack_data_d[{skid_addr_q[1:0], 3'b000} +: 8] = skid_data_q;
                        pack_be_d[skid_addr_q[1:0]]                  = 1'b1;
                        pack_addr_d  = skid_addr_q[BYTE_ADDR_W-1:2];
                        skid_valid_d = 1'b0;
                        if (capture) begin
                            overflow_d = 1'b1;
                        end
                        state_d = StCollect;
                    end else if (capture) begin
                        pack_data_d[{cap_lane, 3'b000} +: 8] = data_i;
                        pack_be_d[cap_lane]                  = 1'b1;
                        pack_addr_d                          = cap_waddr;
                        state_d                              = StCollect;
                    end else begin
                        state_d = session_i ? StCollect : StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            session_q    <= 1'b0;
            pack_data_q  <= '0;
            pack_be_q    <= '0;
            pack_addr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_addr_q  <= '0;
            overflow_q   <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_i;
            session_q    <= session_i;
            pack_data_q  <= pack_data_d;
            pack_be_q    <= pack_be_d;
            pack_addr_q  <= pack_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_addr_q  <= skid_addr_d;
            overflow_q   <= overflow_d;
            words_q      <= words_d;
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [WORD_W-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (start) begin
            checksum_q <= '0;
        end else if (grant) begin
            checksum_q <= checksum_q + (pack_data_q & be_to_mask(pack_be_q));
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

    assign mem_req_o   = (state_q == StWrite);
    assign mem_addr_o  = pack_addr_q;
    assign mem_wdata_o = pack_data_q;
    assign mem_be_o    = pack_be_q;
    assign cpu_rst_no  = !(state_q == StCollect || state_q == StWrite);
    assign overflow_o  = overflow_q;
    assign words_o     = words_q;

endmodule
